// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator controller: FSM states,
// default parameter values and the active-low hex-to-segment table.
package elev_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } state_t;

    localparam int DEF_NUM_FLOORS  = 4;
    localparam int DEF_FLOOR_TICKS = 8;
    localparam int DEF_DOOR_TICKS  = 4;

    // Active-low segments g..a, indexed by hex digit (entry 15 first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment pattern; combinational.
// Bit 7 is the decimal point, driven low (lit) when i_dp is high.
module seg7_decode
    import elev_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_dp,
    output logic [7:0] o_seg
);

    assign o_seg = {~i_dp, SEG_TABLE[i_val]};

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: request latching, direction-keeping travel FSM, door timer.
// Display decoder only exists when ELEV_SEVENSEG_EN is defined; otherwise sevenseg is 8'hFF.
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
    parameter int FLOOR_TICKS = DEF_FLOOR_TICKS,
    parameter int DOOR_TICKS  = DEF_DOOR_TICKS,
    parameter int LW          = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_FLOORS-1:0] call_btn,
    output logic [LW-1:0]         level,
    output logic [7:0]            sevenseg,
    output logic                  moving,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int FCW = $clog2(FLOOR_TICKS) + 1;
    localparam int DCW = $clog2(DOOR_TICKS) + 1;

    state_t                  r_state, w_state_nxt;
    logic [LW-1:0]           r_level, w_level_nxt, w_step_lvl;
    logic                    r_dir_up, w_dir_nxt;
    logic [NUM_FLOORS-1:0]   r_pending, w_req, w_set, w_clr;
    logic [FCW-1:0]          r_cnt, w_cnt_nxt;
    logic [DCW-1:0]          r_door_cnt, w_door_nxt;
    logic                    r_moving, r_door_open;
    logic                    w_above_cur, w_below_cur, w_above_step, w_below_step, w_at_end;

    assign w_step_lvl = (r_state == MOVE_DOWN) ? r_level - LW'(1) : r_level + LW'(1);
    assign w_at_end   = (r_state == MOVE_DOWN) ? (r_level == '0)
                                               : (r_level == LW'(NUM_FLOORS - 1));

    // Decisions see this cycle's buttons so a current-floor call opens the door at once.
    always_comb begin
        w_req        = r_pending | call_btn;
        w_above_cur  = 1'b0;
        w_below_cur  = 1'b0;
        w_above_step = 1'b0;
        w_below_step = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_req[i] && i > int'(r_level))    w_above_cur  = 1'b1;
            if (w_req[i] && i < int'(r_level))    w_below_cur  = 1'b1;
            if (w_req[i] && i > int'(w_step_lvl)) w_above_step = 1'b1;
            if (w_req[i] && i < int'(w_step_lvl)) w_below_step = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_dir_nxt   = r_dir_up;
        w_cnt_nxt   = r_cnt;
        w_door_nxt  = r_door_cnt;
        w_set       = call_btn;
        w_clr       = '0;
        case (r_state)
            IDLE: begin
                if (w_req[r_level]) begin
                    w_state_nxt     = DOOR;
                    w_door_nxt      = '0;
                    w_clr[r_level]  = 1'b1;
                end else if (enable) begin
                    w_cnt_nxt = '0;
                    if (w_above_cur && (r_dir_up || !w_below_cur)) begin
                        w_state_nxt = MOVE_UP;
                        w_dir_nxt   = 1'b1;
                    end else if (w_below_cur) begin
                        w_state_nxt = MOVE_DOWN;
                        w_dir_nxt   = 1'b0;
                    end
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (enable) begin
                    if (w_at_end) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == FCW'(FLOOR_TICKS - 1)) begin
                        w_level_nxt = w_step_lvl;
                        w_cnt_nxt   = '0;
                        if (w_req[w_step_lvl]) begin
                            w_state_nxt       = DOOR;
                            w_door_nxt        = '0;
                            w_clr[w_step_lvl] = 1'b1;
                        end else if ((r_state == MOVE_UP) ? !w_above_step : !w_below_step) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + FCW'(1);
                    end
                end
            end
            DOOR: begin
                w_set[r_level] = 1'b0;
                if (call_btn[r_level]) begin
                    w_door_nxt = '0;
                end else if (enable) begin
                    if (r_door_cnt == DCW'(DOOR_TICKS - 1)) begin
                        w_state_nxt = IDLE;
                        w_door_nxt  = '0;
                    end else begin
                        w_door_nxt = r_door_cnt + DCW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_level     <= '0;
            r_dir_up    <= 1'b1;
            r_pending   <= '0;
            r_cnt       <= '0;
            r_door_cnt  <= '0;
            r_moving    <= 1'b0;
            r_door_open <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_level     <= w_level_nxt;
            r_dir_up    <= w_dir_nxt;
            r_pending   <= (r_pending | w_set) & ~w_clr;
            r_cnt       <= w_cnt_nxt;
            r_door_cnt  <= w_door_nxt;
            r_moving    <= (w_state_nxt == MOVE_UP) || (w_state_nxt == MOVE_DOWN);
            r_door_open <= (w_state_nxt == DOOR);
        end
    end

    assign level     = r_level;
    assign moving    = r_moving;
    assign door_open = r_door_open;
    assign dir_up    = r_dir_up;
    assign pending   = r_pending;

`ifdef ELEV_SEVENSEG_EN
    logic [3:0] w_digit;
    logic       w_dp;
    assign w_digit = 4'(r_level);
    assign w_dp    = (r_state == DOOR);
    seg7_decode u_seg7 (
        .i_val (w_digit),
        .i_dp  (w_dp),
        .o_seg (sevenseg)
    );
`else
    assign sevenseg = 8'hFF;
`endif

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 4, number of served floors; legal range 2..16.
REQ-002 Parameter FLOOR_TICKS, default 8, enabled cycles needed to travel one floor.
REQ-003 Parameter DOOR_TICKS, default 4, enabled cycles the door stays open.
REQ-004 LW = $clog2(NUM_FLOORS) SHALL size all floor indices.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  time-base qualifier; travel and door counters advance only when high.
REQ-008 call_btn  in  NUM_FLOORS  one bit per floor; a high level requests that floor.
REQ-009 level  out  LW  current floor index.
REQ-010 sevenseg  out  8  active-low display, bits[6:0] segments g..a, bit7 decimal point.
REQ-011 moving  out  1  high in MOVE_UP or MOVE_DOWN.
REQ-012 door_open  out  1  high in DOOR.
REQ-013 dir_up  out  1  last or current travel direction, 1 = up.
REQ-014 pending  out  NUM_FLOORS  registered outstanding-request vector.

Function
REQ-015 States SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR.
REQ-016 call_btn[i] high SHALL set pending[i] on the next edge, except when state is DOOR and i == level.
REQ-017 Call for current floor during DOOR SHALL reload the door counter to 0 instead.
REQ-018 Requests SHALL latch regardless of enable.
REQ-019 IDLE: pending[level] -> DOOR; else any pending above and (dir_up or none below) -> MOVE_UP, dir_up=1; else any below -> MOVE_DOWN, dir_up=0; else stay.
REQ-020 MOVE_x: counter increments on enabled cycles; at FLOOR_TICKS-1 and enable, level steps +/-1 and counter clears.
REQ-021 On arrival: pending[new level] -> DOOR; else further pending in same direction -> keep moving; else IDLE.
REQ-022 Entry to DOOR SHALL clear pending[level] in the same edge.
REQ-023 DOOR: after DOOR_TICKS enabled cycles -> IDLE.
REQ-024 level SHALL never exceed NUM_FLOORS-1 nor go below 0; MOVE_UP at top or MOVE_DOWN at 0 SHALL go to IDLE without stepping.
REQ-025 Simultaneous call_btn bits SHALL all latch in one edge.
REQ-026 enable low SHALL freeze counters and state except IDLE->DOOR on a current-floor request.
REQ-027 Outputs moving, door_open, dir_up, level SHALL be registered; sevenseg derived combinationally from level and state.

Reset
REQ-028 reset SHALL force state IDLE, level 0, dir_up 1, pending 0, counters 0, moving 0, door_open 0.
REQ-029 reset mid-travel or mid-door SHALL abandon the operation and discard all requests.
REQ-030 reset has priority over call_btn in the same cycle.

Configuration
REQ-031 Macro ELEV_SEVENSEG_EN defined: sevenseg shows level as hex digit 0..F, decimal point lit (bit7=0) while door_open.
REQ-032 Macro undefined: sevenseg SHALL be constant 8'hFF and no decoder logic synthesised.

Structure
REQ-033 Package elev_pkg SHALL hold the state enum, the hex-to-segment table constant and the default parameter values.
REQ-034 Sub-module seg7_decode (4-bit value + dp in, 8-bit active-low out) SHALL be instantiated only under ELEV_SEVENSEG_EN.

Verification
REQ-035 Defaults, enable=1, reset then call_btn[2] one cycle -> MOVE_UP, level 1 after 8 cycles, level 2 after 16, door_open 4 cycles, then IDLE, pending 0.
REQ-036 At level 0 idle, call_btn[0] -> door_open next edge, pending[0] never set.
REQ-037 Moving up from 0 to 3, call_btn[1] while level=0 -> stop at 1 with door, then continue to 3.
REQ-038 At level 2, dir_up=1, pending[0] and pending[3] set together -> serve 3 first, then 0.
REQ-039 enable held low 20 cycles mid-travel -> level and counter unchanged; resumes counting on enable high.
REQ-040 reset asserted during DOOR at level 3 with pending[0] -> next cycle level 0, pending 0, sevenseg 8'hC0 with macro, 8'hFF without.
